ps2_key_state_tracker: RTL and testbench
========================================

# ps2_key_state_tracker

Synchronous PS/2 Set-2 scancode decoder sitting between the PS/2 byte receiver and the keyboard state consumers (MasterFSM, mainStateHandler, resetScreen). Consumes the receiver's byte stream and produces a level vector of held keys plus single-cycle press/release pulses, all in the CLOCK_50 domain. It handles the F0 break prefix, discards E0 extended sequences, suppresses typematic repeats, and clears stale prefixes with a timeout.

## Interface
- NUM_KEYS, 29: width of key vector; equals `NUMBEROFKEYBOARDINPUTS.
- PREFIX_TIMEOUT, 1_000_000: cycles (20 ms @ 50 MHz) a pending prefix survives without a new byte.
- CLOCK_50  in  1  system clock; all logic on rising edge.
- resetn  in  1  one clock; reset is synchronous and active-high (driven from ~KEY[0]).
- recievedData  in  8  byte from PS/2 receiver; valid only while recievedNewData is high.
- recievedNewData  in  1  one-cycle strobe per received byte.
- clearKeys  in  1  synchronous: release all keys, abandon any prefix, no pulses.
- keyState  out  NUM_KEYS  level per key, 1 = held.
- keyPressPulse  out  1  one cycle high on a make of a released key.
- keyReleasePulse  out  1  one cycle high on a break of a held key.
- lastKeyIndex  out  5  index of key that caused the most recent pulse.
- lastKeyValid  out  1  high once any pulse has occurred since reset/clear.

## Operation
- FSM states: IDLE, BREAK (F0 seen), EXT (E0 seen), EXT_BREAK (E0 F0 seen).
- IDLE: F0 -> BREAK; E0 -> EXT; FA/AA/EE/FE/00/FF -> ignored, stay IDLE; mapped code -> make event; unmapped -> ignored.
- BREAK: F0 -> stay BREAK; mapped code -> break event, -> IDLE; any other byte -> IDLE, no event.
- EXT: F0 -> EXT_BREAK; any other byte -> IDLE, discarded. EXT_BREAK: any byte -> IDLE, discarded.
- Make event, key index k: if keyState[k]=0 set it, pulse keyPressPulse, lastKeyIndex=k; if already 1 (typematic repeat) no change, no pulse.
- Break event: if keyState[k]=1 clear it, pulse keyReleasePulse, lastKeyIndex=k; if already 0 no pulse.
- Key map (index: code): 0 `0E, 1 `16, 2 `1E, 3 `26, 4 `25, 5 `2E, 6 `36, 7 `3D, 8 `3E, 9 `46, 10 `45, 11 `4E, 12 `55, 13 `66, 14 `0D, 15 `15, 16 `1D, 17 `24, 18 `2D, 19 `2C, 20 `35, 21 `3C, 22 `43, 23 `44, 24 `4D, 25 `54, 26 `5B, 27 `5D, 28 `29 (tilde..backspace, tab..backslash, spacebar).
- Timeout counter: cleared on every strobe and in IDLE; increments in other states; on reaching PREFIX_TIMEOUT-1 FSM -> IDLE, no event.
- Priority: resetn > clearKeys > strobe > timeout. Strobe and timeout in the same cycle: byte processed, timeout ignored.

## Timing
- Reset values: keyState=0, both pulses 0, lastKeyIndex=0, lastKeyValid=0, FSM IDLE, counter 0.
- Latency: strobe at edge N -> keyState, pulse, lastKeyIndex visible after edge N+1 (one register stage); pulse high exactly one cycle.
- Back-to-back strobes on consecutive cycles fully supported; at most one pulse per strobe.
- clearKeys: keyState=0, lastKeyValid=0, FSM IDLE on next edge; a strobe in the same cycle is dropped.
- Reset mid-sequence (e.g. after F0): next byte treated from IDLE.

## Structure
- Shared package/header (DefineMacros.vh): key index macros (`keyTilda..`keySpacebar), `NUMBEROFKEYBOARDINPUTS, scancode constants F0/E0, FSM state encodings.
- One natural sub-module: ps2_scancode_lut, combinational byte -> {hit, index[4:0]}; FSM, counter and key register stay in the top.

## Test plan
- Strobe 0x15 -> keyState[15]=1, keyPressPulse one cycle, lastKeyIndex=15; then 0xF0,0x15 -> keyState[15]=0, keyReleasePulse one cycle.
- 0x29 three times (typematic) -> exactly one keyPressPulse, keyState[28]=1 throughout.
- 0xE0,0x75 then 0xE0,0xF0,0x75 then 0x1C -> no pulses, keyState unchanged.
- 0xF0, wait PREFIX_TIMEOUT cycles, 0x16 -> keyState[1]=1 with press pulse (not treated as break).
- Hold keys 3,20 then clearKeys -> keyState=0, no release pulses; resetn after 0xF0 then 0x1E -> press of key 2.
- 0xF0 and timeout expiry in same cycle as next strobe 0x1E (key 2 held) -> break processed, keyReleasePulse.

Source files
------------

// File: rtl/ps2_key_state_tracker_pkg.sv
// Shared definitions for the PS/2 key state tracker slice.
// Contents:
//   - NUMBEROFKEYBOARDINPUTS : width of the held-key vector
//   - KEY_* index constants  : bit position of each tracked key in keyState
//   - SC_BREAK / SC_EXT      : Set-2 break (F0) and extended (E0) prefix bytes
//   - trackerState_t         : decoder FSM states
package ps2_key_state_tracker_pkg;

    localparam int unsigned NUMBEROFKEYBOARDINPUTS = 29;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [4:0] KEY_TILDA      = 5'd0;
    localparam logic [4:0] KEY_ONE        = 5'd1;
    localparam logic [4:0] KEY_TWO        = 5'd2;
    localparam logic [4:0] KEY_THREE      = 5'd3;
    localparam logic [4:0] KEY_FOUR       = 5'd4;
    localparam logic [4:0] KEY_FIVE       = 5'd5;
    localparam logic [4:0] KEY_SIX        = 5'd6;
    localparam logic [4:0] KEY_SEVEN      = 5'd7;
    localparam logic [4:0] KEY_EIGHT      = 5'd8;
    localparam logic [4:0] KEY_NINE       = 5'd9;
    localparam logic [4:0] KEY_ZERO       = 5'd10;
    localparam logic [4:0] KEY_MINUS      = 5'd11;
    localparam logic [4:0] KEY_EQUALS     = 5'd12;
    localparam logic [4:0] KEY_BACKSPACE  = 5'd13;
    localparam logic [4:0] KEY_TAB        = 5'd14;
    localparam logic [4:0] KEY_Q          = 5'd15;
    localparam logic [4:0] KEY_W          = 5'd16;
    localparam logic [4:0] KEY_E          = 5'd17;
    localparam logic [4:0] KEY_R          = 5'd18;
    localparam logic [4:0] KEY_T          = 5'd19;
    localparam logic [4:0] KEY_Y          = 5'd20;
    localparam logic [4:0] KEY_U          = 5'd21;
    localparam logic [4:0] KEY_I          = 5'd22;
    localparam logic [4:0] KEY_O          = 5'd23;
    localparam logic [4:0] KEY_P          = 5'd24;
    localparam logic [4:0] KEY_LBRACKET   = 5'd25;
    localparam logic [4:0] KEY_RBRACKET   = 5'd26;
    localparam logic [4:0] KEY_BACKSLASH  = 5'd27;
    localparam logic [4:0] KEY_SPACEBAR   = 5'd28;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_EXT,
        ST_EXT_BREAK
    } trackerState_t;

endpackage

// File: rtl/ps2_key_state_tracker_lut.sv
// Combinational Set-2 scancode lookup.
// Ports:
//   scanCode  in  8  received byte
//   hit       out 1  byte is one of the tracked make codes
//   keyIndex  out 5  keyState bit for that code (0 when no hit)
module ps2_scancode_lut
    import ps2_key_state_tracker_pkg::*;
(
    input  logic [7:0] scanCode,
    output logic       hit,
    output logic [4:0] keyIndex
);

    always_comb begin
        hit      = 1'b1;
        keyIndex = '0;
        case (scanCode)
            8'h0E: keyIndex = KEY_TILDA;
            8'h16: keyIndex = KEY_ONE;
            8'h1E: keyIndex = KEY_TWO;
            8'h26: keyIndex = KEY_THREE;
            8'h25: keyIndex = KEY_FOUR;
            8'h2E: keyIndex = KEY_FIVE;
            8'h36: keyIndex = KEY_SIX;
            8'h3D: keyIndex = KEY_SEVEN;
            8'h3E: keyIndex = KEY_EIGHT;
            8'h46: keyIndex = KEY_NINE;
            8'h45: keyIndex = KEY_ZERO;
            8'h4E: keyIndex = KEY_MINUS;
            8'h55: keyIndex = KEY_EQUALS;
            8'h66: keyIndex = KEY_BACKSPACE;
            8'h0D: keyIndex = KEY_TAB;
            8'h15: keyIndex = KEY_Q;
            8'h1D: keyIndex = KEY_W;
            8'h24: keyIndex = KEY_E;
            8'h2D: keyIndex = KEY_R;
            8'h2C: keyIndex = KEY_T;
            8'h35: keyIndex = KEY_Y;
            8'h3C: keyIndex = KEY_U;
            8'h43: keyIndex = KEY_I;
            8'h44: keyIndex = KEY_O;
            8'h4D: keyIndex = KEY_P;
            8'h54: keyIndex = KEY_LBRACKET;
            8'h5B: keyIndex = KEY_RBRACKET;
            8'h5D: keyIndex = KEY_BACKSLASH;
            8'h29: keyIndex = KEY_SPACEBAR;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_key_state_tracker.sv
// PS/2 Set-2 byte stream -> held-key vector plus press/release pulses.
// Ports:
//   CLOCK_50         in  1         system clock, rising edge
//   resetn           in  1         synchronous reset, active high
//   recievedData     in  8         byte from the PS/2 receiver
//   recievedNewData  in  1         one-cycle strobe qualifying recievedData
//   clearKeys        in  1         release all keys, drop prefix, no pulses
//   keyState         out NUM_KEYS  1 = key held
//   keyPressPulse    out 1         one cycle on make of a released key
//   keyReleasePulse  out 1         one cycle on break of a held key
//   lastKeyIndex     out 5         key behind the most recent pulse
//   lastKeyValid     out 1         a pulse has occurred since reset/clear
// F0 prefixes a break, E0 sequences are swallowed, repeats of a held key
// are silent, and a prefix left pending for PREFIX_TIMEOUT cycles is dropped.
module ps2_key_state_tracker
    import ps2_key_state_tracker_pkg::*;
#(
    parameter int unsigned NUM_KEYS       = NUMBEROFKEYBOARDINPUTS,
    parameter int unsigned PREFIX_TIMEOUT = 1_000_000
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [7:0]          recievedData,
    input  logic                recievedNewData,
    input  logic                clearKeys,
    output logic [NUM_KEYS-1:0] keyState,
    output logic                keyPressPulse,
    output logic                keyReleasePulse,
    output logic [4:0]          lastKeyIndex,
    output logic                lastKeyValid
);

    localparam int unsigned CNT_W = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

    trackerState_t    state;
    trackerState_t    nextState;
    logic [CNT_W-1:0] timeoutCnt;
    logic             lutHit;
    logic [4:0]       lutIndex;
    logic             makeEvent;
    logic             breakEvent;

    ps2_scancode_lut u_lut (
        .scanCode (recievedData),
        .hit      (lutHit),
        .keyIndex (lutIndex)
    );

    // A strobe always wins over a timeout expiring in the same cycle.
    always_comb begin
        nextState  = state;
        makeEvent  = 1'b0;
        breakEvent = 1'b0;
        if (recievedNewData) begin
            case (state)
                ST_IDLE: begin
                    if (recievedData == SC_BREAK) begin
                        nextState = ST_BREAK;
                    end else if (recievedData == SC_EXT) begin
                        nextState = ST_EXT;
                    end else begin
                        // Acks and status bytes are not in the map, so they fall out here.
                        makeEvent = lutHit;
                    end
                end
                ST_BREAK: begin
                    if (recievedData != SC_BREAK) begin
                        nextState  = ST_IDLE;
                        breakEvent = lutHit;
                    end
                end
                ST_EXT: begin
                    nextState = (recievedData == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
                end
                default: begin
                    nextState = ST_IDLE;
                end
            endcase
        end else if (state != ST_IDLE && timeoutCnt == TIMEOUT_LAST) begin
            nextState = ST_IDLE;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (resetn) begin
            state           <= ST_IDLE;
            timeoutCnt      <= '0;
            keyState        <= '0;
            keyPressPulse   <= 1'b0;
            keyReleasePulse <= 1'b0;
            lastKeyIndex    <= '0;
            lastKeyValid    <= 1'b0;
        end else if (clearKeys) begin
            state           <= ST_IDLE;
            timeoutCnt      <= '0;
            keyState        <= '0;
            keyPressPulse   <= 1'b0;
            keyReleasePulse <= 1'b0;
            lastKeyValid    <= 1'b0;
        end else begin
            state           <= nextState;
            keyPressPulse   <= 1'b0;
            keyReleasePulse <= 1'b0;
            // Clearing whenever the next state is IDLE also covers the expiry
            // cycle, so the counter never has to hold PREFIX_TIMEOUT itself.
            if (recievedNewData || nextState == ST_IDLE) begin
                timeoutCnt <= '0;
            end else begin
                timeoutCnt <= timeoutCnt + 1'b1;
            end
            if (makeEvent && !keyState[lutIndex]) begin
                keyState[lutIndex] <= 1'b1;
                keyPressPulse      <= 1'b1;
                lastKeyIndex       <= lutIndex;
                lastKeyValid       <= 1'b1;
            end
            if (breakEvent && keyState[lutIndex]) begin
                keyState[lutIndex] <= 1'b0;
                keyReleasePulse    <= 1'b1;
                lastKeyIndex       <= lutIndex;
                lastKeyValid       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_state_tracker.sv
module tb_ps2_key_state_tracker;

    localparam int unsigned NK = 29;
    localparam int unsigned T  = 16;

    logic          CLOCK_50 = 1'b0;
    logic          resetn = 1'b1;
    logic [7:0]    recievedData = 8'h00;
    logic          recievedNewData = 1'b0;
    logic          clearKeys = 1'b0;
    logic [NK-1:0] keyState;
    logic          keyPressPulse;
    logic          keyReleasePulse;
    logic [4:0]    lastKeyIndex;
    logic          lastKeyValid;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_key_state_tracker #(
        .NUM_KEYS       (NK),
        .PREFIX_TIMEOUT (T)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .resetn          (resetn),
        .recievedData    (recievedData),
        .recievedNewData (recievedNewData),
        .clearKeys       (clearKeys),
        .keyState        (keyState),
        .keyPressPulse   (keyPressPulse),
        .keyReleasePulse (keyReleasePulse),
        .lastKeyIndex    (lastKeyIndex),
        .lastKeyValid    (lastKeyValid)
    );

    typedef struct {
        logic [7:0] code;
        logic       press;
        logic       rel;
        logic [4:0] idx;
    } stim_t;

    typedef struct {
        logic          press;
        logic          rel;
        logic [4:0]    idx;
        logic [NK-1:0] keys;
    } exp_t;

    exp_t          sbq[$];
    logic [NK-1:0] held = '0;
    int            nCompared = 0;
    int            nMismatched = 0;

    function automatic stim_t mk(input logic [7:0] code, input logic press,
                                 input logic rel, input int idx);
        stim_t s;
        s.code  = code;
        s.press = press;
        s.rel   = rel;
        s.idx   = 5'(idx);
        return s;
    endfunction

    // Drive one byte; it is sampled on the next rising edge, outputs read 1 ns later.
    task automatic sendByte(input logic [7:0] b);
        recievedData    = b;
        recievedNewData = 1'b1;
        @(posedge CLOCK_50);
        #1;
        recievedNewData = 1'b0;
    endtask

    task automatic pushAndSend(input stim_t s);
        exp_t e;
        if (s.press) held[s.idx] = 1'b1;
        if (s.rel)   held[s.idx] = 1'b0;
        e.press = s.press;
        e.rel   = s.rel;
        e.idx   = s.idx;
        e.keys  = held;
        sbq.push_back(e);
        sendByte(s.code);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        idle(2);
        nCompared++;
        if ({keyState, keyPressPulse, keyReleasePulse, lastKeyIndex, lastKeyValid} !== '0) begin
            nMismatched++;
            $display("FAIL reset: got keys=%h p=%b r=%b idx=%0d v=%b want all zero",
                     keyState, keyPressPulse, keyReleasePulse, lastKeyIndex, lastKeyValid);
        end
        resetn = 1'b0;
        held   = '0;
        idle(1);
    endtask

    task automatic test_press_release();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(8'h15, 1, 0, 15));
        s.push_back(mk(8'hF0, 0, 0, 0));
        s.push_back(mk(8'h15, 0, 1, 15));
        foreach (s[i]) begin
            pushAndSend(s[i]);
            e = sbq.pop_front();
            nCompared++;
            if ({keyPressPulse, keyReleasePulse, keyState} !== {e.press, e.rel, e.keys}) begin
                nMismatched++;
                $display("FAIL press_release[%0d] got p=%b r=%b keys=%h want p=%b r=%b keys=%h",
                         i, keyPressPulse, keyReleasePulse, keyState, e.press, e.rel, e.keys);
            end
            if (e.press || e.rel) begin
                nCompared++;
                if (lastKeyIndex !== e.idx || lastKeyValid !== 1'b1) begin
                    nMismatched++;
                    $display("FAIL press_release_idx[%0d] got idx=%0d v=%b want idx=%0d v=1",
                             i, lastKeyIndex, lastKeyValid, e.idx);
                end
                idle(1);
                nCompared++;
                if ({keyPressPulse, keyReleasePulse} !== 2'b00) begin
                    nMismatched++;
                    $display("FAIL pulse_width[%0d] got p=%b r=%b want p=0 r=0",
                             i, keyPressPulse, keyReleasePulse);
                end
            end
        end
    endtask

    task automatic test_typematic();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(8'h29, 1, 0, 28));
        s.push_back(mk(8'h29, 0, 0, 0));
        s.push_back(mk(8'h29, 0, 0, 0));
        s.push_back(mk(8'hF0, 0, 0, 0));
        s.push_back(mk(8'h29, 0, 1, 28));
        s.push_back(mk(8'hF0, 0, 0, 0));
        s.push_back(mk(8'h29, 0, 0, 0));
        foreach (s[i]) begin
            pushAndSend(s[i]);
            e = sbq.pop_front();
            nCompared++;
            if ({keyPressPulse, keyReleasePulse, keyState} !== {e.press, e.rel, e.keys}) begin
                nMismatched++;
                $display("FAIL typematic[%0d] got p=%b r=%b keys=%h want p=%b r=%b keys=%h",
                         i, keyPressPulse, keyReleasePulse, keyState, e.press, e.rel, e.keys);
            end
            if (e.press || e.rel) begin
                nCompared++;
                if (lastKeyIndex !== e.idx) begin
                    nMismatched++;
                    $display("FAIL typematic_idx[%0d] got %0d want %0d", i, lastKeyIndex, e.idx);
                end
            end
        end
    endtask

    task automatic test_extended();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(8'h0E, 1, 0, 0));
        s.push_back(mk(8'hE0, 0, 0, 0));
        s.push_back(mk(8'h75, 0, 0, 0));
        s.push_back(mk(8'hE0, 0, 0, 0));
        s.push_back(mk(8'hF0, 0, 0, 0));
        s.push_back(mk(8'h75, 0, 0, 0));
        s.push_back(mk(8'hE0, 0, 0, 0));
        s.push_back(mk(8'h16, 0, 0, 0));
        s.push_back(mk(8'hE0, 0, 0, 0));
        s.push_back(mk(8'hF0, 0, 0, 0));
        s.push_back(mk(8'h0E, 0, 0, 0));
        s.push_back(mk(8'h1C, 0, 0, 0));
        s.push_back(mk(8'hFA, 0, 0, 0));
        s.push_back(mk(8'hAA, 0, 0, 0));
        s.push_back(mk(8'hF0, 0, 0, 0));
        s.push_back(mk(8'h1C, 0, 0, 0));
        s.push_back(mk(8'h15, 1, 0, 15));
        s.push_back(mk(8'hF0, 0, 0, 0));
        s.push_back(mk(8'h0E, 0, 1, 0));
        s.push_back(mk(8'hF0, 0, 0, 0));
        s.push_back(mk(8'h15, 0, 1, 15));
        foreach (s[i]) begin
            pushAndSend(s[i]);
            e = sbq.pop_front();
            nCompared++;
            if ({keyPressPulse, keyReleasePulse, keyState} !== {e.press, e.rel, e.keys}) begin
                nMismatched++;
                $display("FAIL extended[%0d] byte %h got p=%b r=%b keys=%h want p=%b r=%b keys=%h",
                         i, s[i].code, keyPressPulse, keyReleasePulse, keyState, e.press, e.rel, e.keys);
            end
            if (e.press || e.rel) begin
                nCompared++;
                if (lastKeyIndex !== e.idx) begin
                    nMismatched++;
                    $display("FAIL extended_idx[%0d] got %0d want %0d", i, lastKeyIndex, e.idx);
                end
            end
        end
    endtask

    // A stale F0 must be forgotten after T idle cycles.
    task automatic test_timeout();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(8'hF0, 0, 0, 0));
        s.push_back(mk(8'h16, 1, 0, 1));
        s.push_back(mk(8'hF0, 0, 0, 0));
        s.push_back(mk(8'h16, 0, 1, 1));
        foreach (s[i]) begin
            pushAndSend(s[i]);
            if (i == 0) idle(T);
            e = sbq.pop_front();
            nCompared++;
            if ({keyPressPulse, keyReleasePulse, keyState} !== {e.press, e.rel, e.keys}) begin
                nMismatched++;
                $display("FAIL timeout[%0d] got p=%b r=%b keys=%h want p=%b r=%b keys=%h",
                         i, keyPressPulse, keyReleasePulse, keyState, e.press, e.rel, e.keys);
            end
            if (e.press || e.rel) begin
                nCompared++;
                if (lastKeyIndex !== e.idx) begin
                    nMismatched++;
                    $display("FAIL timeout_idx[%0d] got %0d want %0d", i, lastKeyIndex, e.idx);
                end
            end
        end
    endtask

    task automatic test_clear();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(8'h26, 1, 0, 3));
        s.push_back(mk(8'h35, 1, 0, 20));
        s.push_back(mk(8'hF0, 0, 0, 0));
        foreach (s[i]) begin
            pushAndSend(s[i]);
            e = sbq.pop_front();
            nCompared++;
            if ({keyPressPulse, keyReleasePulse, keyState} !== {e.press, e.rel, e.keys}) begin
                nMismatched++;
                $display("FAIL clear_setup[%0d] got p=%b r=%b keys=%h want p=%b r=%b keys=%h",
                         i, keyPressPulse, keyReleasePulse, keyState, e.press, e.rel, e.keys);
            end
        end
        // Clear with a simultaneous strobe: the byte must be dropped.
        clearKeys       = 1'b1;
        recievedData    = 8'h1E;
        recievedNewData = 1'b1;
        @(posedge CLOCK_50);
        #1;
        clearKeys       = 1'b0;
        recievedNewData = 1'b0;
        held            = '0;
        nCompared++;
        if ({keyState, keyPressPulse, keyReleasePulse, lastKeyValid} !== '0) begin
            nMismatched++;
            $display("FAIL clear: got keys=%h p=%b r=%b v=%b want keys=0 p=0 r=0 v=0",
                     keyState, keyPressPulse, keyReleasePulse, lastKeyValid);
        end
        // The pending F0 was abandoned, so 1E is a make.
        s.delete();
        s.push_back(mk(8'h1E, 1, 0, 2));
        s.push_back(mk(8'hF0, 0, 0, 0));
        s.push_back(mk(8'h1E, 0, 1, 2));
        foreach (s[i]) begin
            pushAndSend(s[i]);
            e = sbq.pop_front();
            nCompared++;
            if ({keyPressPulse, keyReleasePulse, keyState, lastKeyValid} !== {e.press, e.rel, e.keys, 1'b1}) begin
                nMismatched++;
                $display("FAIL clear_after[%0d] got p=%b r=%b keys=%h v=%b want p=%b r=%b keys=%h v=1",
                         i, keyPressPulse, keyReleasePulse, keyState, lastKeyValid, e.press, e.rel, e.keys);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        pushAndSend(mk(8'hF0, 0, 0, 0));
        e = sbq.pop_front();
        nCompared++;
        if ({keyPressPulse, keyReleasePulse} !== {e.press, e.rel}) begin
            nMismatched++;
            $display("FAIL reset_mid_prefix got p=%b r=%b want p=0 r=0", keyPressPulse, keyReleasePulse);
        end
        resetn = 1'b1;
        idle(1);
        resetn = 1'b0;
        held   = '0;
        pushAndSend(mk(8'h1E, 1, 0, 2));
        e = sbq.pop_front();
        nCompared++;
        if ({keyPressPulse, keyReleasePulse, keyState, lastKeyIndex} !== {e.press, e.rel, e.keys, e.idx}) begin
            nMismatched++;
            $display("FAIL reset_mid got p=%b r=%b keys=%h idx=%0d want p=%b r=%b keys=%h idx=%0d",
                     keyPressPulse, keyReleasePulse, keyState, lastKeyIndex, e.press, e.rel, e.keys, e.idx);
        end
    endtask

    // Key 2 is held; the break byte lands on the very cycle the prefix would expire.
    task automatic test_timeout_coincident();
        exp_t e;
        pushAndSend(mk(8'hF0, 0, 0, 0));
        e = sbq.pop_front();
        idle(T - 1);
        pushAndSend(mk(8'h1E, 0, 1, 2));
        e = sbq.pop_front();
        nCompared++;
        if ({keyPressPulse, keyReleasePulse, keyState, lastKeyIndex} !== {e.press, e.rel, e.keys, e.idx}) begin
            nMismatched++;
            $display("FAIL timeout_coincident got p=%b r=%b keys=%h idx=%0d want p=%b r=%b keys=%h idx=%0d",
                     keyPressPulse, keyReleasePulse, keyState, lastKeyIndex, e.press, e.rel, e.keys, e.idx);
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(8'h16, 1, 0, 1));
        s.push_back(mk(8'h1E, 1, 0, 2));
        s.push_back(mk(8'hF0, 0, 0, 0));
        s.push_back(mk(8'h16, 0, 1, 1));
        s.push_back(mk(8'h16, 1, 0, 1));
        s.push_back(mk(8'hF0, 0, 0, 0));
        s.push_back(mk(8'hF0, 0, 0, 0));
        s.push_back(mk(8'h1E, 0, 1, 2));
        s.push_back(mk(8'h5D, 1, 0, 27));
        s.push_back(mk(8'hF0, 0, 0, 0));
        s.push_back(mk(8'h16, 0, 1, 1));
        foreach (s[i]) begin
            pushAndSend(s[i]);
            e = sbq.pop_front();
            nCompared++;
            if ({keyPressPulse, keyReleasePulse, keyState} !== {e.press, e.rel, e.keys}) begin
                nMismatched++;
                $display("FAIL back_to_back[%0d] got p=%b r=%b keys=%h want p=%b r=%b keys=%h",
                         i, keyPressPulse, keyReleasePulse, keyState, e.press, e.rel, e.keys);
            end
            if (e.press || e.rel) begin
                nCompared++;
                if (lastKeyIndex !== e.idx) begin
                    nMismatched++;
                    $display("FAIL back_to_back_idx[%0d] got %0d want %0d", i, lastKeyIndex, e.idx);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_typematic();
        test_extended();
        test_timeout();
        test_clear();
        test_reset_mid();
        test_timeout_coincident();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
